// File: rtl/mem_line_xfer_ctrl.sv
// Line-granular sequencer in front of a single-port synchronous-read RAM.
// Splits fill/writeback requests into word beats and hides the one-cycle read latency.
module mem_line_xfer_ctrl #(
    parameter int AWIDTH   = 3,
    parameter int DWIDTH   = 32,
    parameter int WPL_LOG2 = 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_write,
    input  logic [AWIDTH-WPL_LOG2-1:0]      req_line_addr,
    input  logic [DWIDTH*(1<<WPL_LOG2)-1:0] req_wdata,
    output logic                            rsp_valid,
    output logic                            rsp_write,
    output logic [DWIDTH*(1<<WPL_LOG2)-1:0] rsp_rdata,
    output logic [AWIDTH-1:0]               mem_addr,
    output logic [DWIDTH-1:0]               mem_din,
    output logic                            mem_we,
    input  logic [DWIDTH-1:0]               mem_dout
);

    localparam int WPL = 1 << WPL_LOG2;
    localparam int LW  = DWIDTH * WPL;
    localparam int BW  = (WPL_LOG2 > 0) ? WPL_LOG2 : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(WPL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RD_DRAIN,
        S_RESP
    } state_t;

    state_t              state_q;
    logic [BW-1:0]       beat_q;
    logic                wr_q;
    logic [LW-1:0]       wdata_q;
    logic [LW-1:0]       buf_q;
    logic [LW-1:0]       rsp_rdata_q;
    logic                rsp_valid_q;
    logic                rsp_write_q;
    logic [AWIDTH-1:0]   mem_addr_q;
    logic [DWIDTH-1:0]   mem_din_q;
    logic                mem_we_q;

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign mem_we    = mem_we_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            buf_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    mem_we_q <= 1'b0;
                    if (req_valid) begin
                        beat_q     <= '0;
                        wr_q       <= req_write;
                        mem_addr_q <= AWIDTH'(req_line_addr) << WPL_LOG2;
                        if (req_write) begin
                            // Word 0 goes out now; the rest is shifted down one word per beat.
                            mem_din_q <= req_wdata[DWIDTH-1:0];
                            wdata_q   <= req_wdata >> DWIDTH;
                            mem_we_q  <= 1'b1;
                            state_q   <= S_WR;
                        end else begin
                            state_q   <= S_RD;
                        end
                    end
                end
                S_WR: begin
                    if (beat_q == LAST_BEAT) begin
                        mem_we_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= wr_q;
                        state_q     <= S_RESP;
                    end else begin
                        beat_q     <= beat_q + BW'(1);
                        mem_addr_q <= mem_addr_q + AWIDTH'(1);
                        mem_din_q  <= wdata_q[DWIDTH-1:0];
                        wdata_q    <= wdata_q >> DWIDTH;
                    end
                end
                S_RD: begin
                    // mem_dout lags the address by one beat; word k-1 lands here during beat k.
                    if (beat_q != '0) begin
                        buf_q <= LW'({mem_dout, buf_q} >> DWIDTH);
                    end
                    if (beat_q == LAST_BEAT) begin
                        state_q <= S_RD_DRAIN;
                    end else begin
                        beat_q     <= beat_q + BW'(1);
                        mem_addr_q <= mem_addr_q + AWIDTH'(1);
                    end
                end
                S_RD_DRAIN: begin
                    rsp_rdata_q <= LW'({mem_dout, buf_q} >> DWIDTH);
                    rsp_valid_q <= 1'b1;
                    rsp_write_q <= wr_q;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_line_xfer_ctrl.sv
// Bench for mem_line_xfer_ctrl: transaction-level reference model with per-cycle compare,
// directed scenarios with literal expectations, random traffic, and a WPL=1 instance.
module tb_mem_line_xfer_ctrl;

    localparam int AW  = 3;
    localparam int DW  = 32;
    localparam int WL  = 1;
    localparam int WPL = 1 << WL;
    localparam int LW  = DW * WPL;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    // Main instance (WPL = 2)
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [AW-WL-1:0]  req_line_addr = '0;
    logic [LW-1:0]     req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_write;
    logic [LW-1:0]     rsp_rdata;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_din;
    logic              mem_we;
    logic [DW-1:0]     mem_dout;

    // Second instance (WPL = 1)
    logic              b_req_valid = 1'b0;
    logic              b_req_ready;
    logic              b_req_write = 1'b0;
    logic [AW-1:0]     b_req_line_addr = '0;
    logic [DW-1:0]     b_req_wdata = '0;
    logic              b_rsp_valid;
    logic              b_rsp_write;
    logic [DW-1:0]     b_rsp_rdata;
    logic [AW-1:0]     b_mem_addr;
    logic [DW-1:0]     b_mem_din;
    logic              b_mem_we;
    logic [DW-1:0]     b_mem_dout;

    mem_line_xfer_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .WPL_LOG2(WL)) u_dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_line_addr(req_line_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
    );

    mem_line_xfer_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .WPL_LOG2(0)) u_dut1 (
        .clock(clock), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_line_addr(b_req_line_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_write(b_rsp_write), .rsp_rdata(b_rsp_rdata),
        .mem_addr(b_mem_addr), .mem_din(b_mem_din), .mem_we(b_mem_we), .mem_dout(b_mem_dout)
    );

    // Synchronous-read RAMs: address latched each edge, data out after the edge
    logic [DW-1:0] ram0 [0:7];
    logic [DW-1:0] ram1 [0:7];
    logic [DW-1:0] ref_mem [0:7];

    always @(posedge clock) begin
        if (mem_we) ram0[mem_addr] <= mem_din;
        mem_dout <= ram0[mem_addr];
        if (b_mem_we) ram1[b_mem_addr] <= b_mem_din;
        b_mem_dout <= ram1[b_mem_addr];
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whole-transaction timing from the accept edge
    int            e_cnt = 0;
    int            t_acc = 0;
    bit            busy  = 1'b0;
    bit            m_wr  = 1'b0;
    int            m_line = 0;
    logic [LW-1:0] m_data = '0;
    logic          exp_ready = 1'b1;
    logic          exp_we    = 1'b0;
    logic          exp_rv    = 1'b0;
    logic          exp_rw    = 1'b0;
    logic          chk_addr  = 1'b0;
    logic [AW-1:0] exp_addr  = '0;
    logic [DW-1:0] exp_din   = '0;
    logic [LW-1:0] exp_rdata = '0;
    bit            cmp_en    = 1'b0;

    always @(posedge clock or posedge reset) begin : model
        int k;
        if (reset) begin
            busy = 1'b0; exp_ready = 1'b1; exp_we = 1'b0; exp_rv = 1'b0;
            exp_rw = 1'b0; chk_addr = 1'b0; exp_rdata = '0;
        end else begin
            e_cnt++;
            if (!busy && req_valid) begin
                busy   = 1'b1;
                t_acc  = e_cnt;
                m_wr   = req_write;
                m_line = int'(req_line_addr);
                if (req_write) m_data = req_wdata;
                else for (int w = 0; w < WPL; w++) m_data[w*DW +: DW] = ref_mem[m_line*WPL + w];
            end
            exp_we = 1'b0; exp_rv = 1'b0; chk_addr = 1'b0;
            if (busy) begin
                k = e_cnt - t_acc;
                if (m_wr) begin
                    if (k >= 1 && k <= WPL) ref_mem[m_line*WPL + k - 1] = m_data[(k-1)*DW +: DW];
                    if (k < WPL) begin
                        exp_we = 1'b1; chk_addr = 1'b1;
                        exp_addr = AW'(m_line*WPL + k);
                        exp_din = m_data[k*DW +: DW];
                    end
                    if (k == WPL) begin exp_rv = 1'b1; exp_rw = 1'b1; end
                    if (k == WPL + 1) busy = 1'b0;
                end else begin
                    if (k <= WPL) begin
                        chk_addr = 1'b1;
                        exp_addr = AW'(m_line*WPL + ((k < WPL) ? k : WPL - 1));
                    end
                    if (k == WPL + 1) begin exp_rv = 1'b1; exp_rw = 1'b0; exp_rdata = m_data; end
                    if (k == WPL + 2) busy = 1'b0;
                end
            end
            exp_ready = !busy;
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            check("req_ready", 64'(req_ready), 64'(exp_ready));
            check("mem_we", 64'(mem_we), 64'(exp_we));
            check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
            if (exp_rv)   check("rsp_write", 64'(rsp_write), 64'(exp_rw));
            if (chk_addr) check("mem_addr", 64'(mem_addr), 64'(exp_addr));
            if (exp_we)   check("mem_din", 64'(mem_din), 64'(exp_din));
        end
    end

    // Issue one request from an idle controller; returns response latency and payload
    task automatic issue(input bit wr, input int line, input logic [LW-1:0] wd, input bit hold,
                         output int lat, output logic rw, output logic [LW-1:0] rd);
        @(negedge clock);
        req_valid = 1'b1; req_write = wr;
        req_line_addr = (AW-WL)'(line); req_wdata = wd;
        @(posedge clock);
        @(negedge clock);
        lat = 0;
        if (hold) begin
            @(posedge clock); @(negedge clock); lat = 1;
        end
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_line_addr = (AW-WL)'($urandom);
        req_wdata = {$urandom, $urandom};
        while (!rsp_valid && lat < 20) begin
            @(posedge clock); @(negedge clock); lat++;
        end
        rw = rsp_write;
        rd = rsp_rdata;
        @(posedge clock); @(negedge clock);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int lat;
        int cnt;
        logic rw;
        logic [LW-1:0] rd;
        for (int i = 0; i < 8; i++) begin
            ram0[i] = 32'h1000_0000 + i;
            ram1[i] = 32'h1000_0000 + i;
            ref_mem[i] = 32'h1000_0000 + i;
        end
        #1 reset = 1'b1;
        #2;
        check("rst mem_we", 64'(mem_we), 64'd0);
        check("rst mem_addr", 64'(mem_addr), 64'd0);
        check("rst mem_din", 64'(mem_din), 64'd0);
        check("rst rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst req_ready", 64'(req_ready), 64'd1);
        check("rst b_rsp_rdata", 64'(b_rsp_rdata), 64'd0);
        cmp_en = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b0;

        // 1: fill line 2
        issue(1'b0, 2, '0, 1'b0, lat, rw, rd);
        check("t1 latency", 64'(lat), 64'd3);
        check("t1 rdata", rd, 64'h10000005_10000004);
        check("t1 rsp_write", 64'(rw), 64'd0);

        // 2: writeback line 1, then fill it back
        issue(1'b1, 1, 64'hBEEF0003_CAFE0002, 1'b0, lat, rw, rd);
        check("t2 latency", 64'(lat), 64'd2);
        check("t2 rsp_write", 64'(rw), 64'd1);
        check("t2 rdata held", rd, 64'h10000005_10000004);
        check("t2 ram[2]", 64'(ram0[2]), 64'hCAFE0002);
        check("t2 ram[3]", 64'(ram0[3]), 64'hBEEF0003);
        issue(1'b0, 1, '0, 1'b0, lat, rw, rd);
        check("t2 readback", rd, 64'hBEEF0003_CAFE0002);

        // 3: back-to-back with req_valid held high
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_line_addr = 2'd0;
        req_wdata = 64'h0BAD0001_0BAD0000;
        @(posedge clock);
        @(negedge clock);
        req_write = 1'b0; req_line_addr = 2'd3;
        repeat (4) @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        cnt = 0;
        while (!rsp_valid && cnt < 20) begin @(negedge clock); cnt++; end
        check("t3 second accept latency", 64'(cnt), 64'd3);
        check("t3 rdata", 64'(rsp_rdata), 64'h10000007_10000006);
        check("t3 ram[0]", 64'(ram0[0]), 64'h0BAD0000);
        @(negedge clock);

        // 4: reset during writeback after first beat
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_line_addr = 2'd3;
        req_wdata = 64'hAAAA0007_55550006;
        @(posedge clock);
        @(negedge clock) req_valid = 1'b0;
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("t4 mem_we after reset", 64'(mem_we), 64'd0);
        check("t4 rsp_valid after reset", 64'(rsp_valid), 64'd0);
        @(posedge clock);
        @(negedge clock) reset = 1'b0;
        #1;
        check("t4 req_ready after release", 64'(req_ready), 64'd1);
        check("t4 ram[6]", 64'(ram0[6]), 64'h55550006);
        check("t4 ram[7]", 64'(ram0[7]), 64'h10000007);
        repeat (4) @(negedge clock);

        // 5: write completion leaves fill data visible
        issue(1'b0, 2, '0, 1'b0, lat, rw, rd);
        check("t5 fill rdata", rd, 64'h10000005_10000004);
        issue(1'b1, 0, 64'h12345678_9ABCDEF0, 1'b0, lat, rw, rd);
        check("t5 rsp_write", 64'(rw), 64'd1);
        check("t5 rdata held", rd, 64'h10000005_10000004);

        // 6: single-word lines
        @(negedge clock);
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_line_addr = 3'd5;
        @(posedge clock);
        @(negedge clock) b_req_valid = 1'b0;
        check("t6 b_mem_addr", 64'(b_mem_addr), 64'd5);
        check("t6 b_req_ready busy", 64'(b_req_ready), 64'd0);
        cnt = 0;
        while (!b_rsp_valid && cnt < 20) begin @(negedge clock); cnt++; end
        check("t6 latency", 64'(cnt), 64'd2);
        check("t6 rdata", 64'(b_rsp_rdata), 64'h10000005);
        check("t6 rsp_write", 64'(b_rsp_write), 64'd0);
        @(negedge clock);
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_line_addr = 3'd2;
        b_req_wdata = 32'hDEAD0002;
        @(posedge clock);
        @(negedge clock) b_req_valid = 1'b0;
        check("t6 b_mem_we", 64'(b_mem_we), 64'd1);
        cnt = 0;
        while (!b_rsp_valid && cnt < 20) begin @(negedge clock); cnt++; end
        check("t6 write latency", 64'(cnt), 64'd1);
        check("t6 b_mem_we low in resp", 64'(b_mem_we), 64'd0);
        check("t6 ram1[2]", 64'(ram1[2]), 64'hDEAD0002);
        @(negedge clock);

        // Random traffic against the model
        for (int n = 0; n < 60; n++) begin
            bit wr;
            bit hold;
            int line;
            logic [LW-1:0] wd;
            wr   = 1'($urandom);
            hold = 1'($urandom);
            line = int'($urandom_range(0, 3));
            wd   = {$urandom, $urandom};
            repeat ($urandom_range(0, 2)) @(negedge clock);
            issue(wr, line, wd, hold, lat, rw, rd);
            check("rnd latency", 64'(lat), wr ? 64'(WPL) : 64'(WPL + 1));
        end

        repeat (3) @(negedge clock);
        for (int i = 0; i < 8; i++) check("final ram", 64'(ram0[i]), 64'(ref_mem[i]));
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
